// File: rtl/hazard_ctrl_pkg.sv
// Shared hazard-bus encodings, controller state encodings and small helpers
// for the pipeline hazard controller.
package hazard_ctrl_pkg;

    localparam logic [3:0] HAZ_NONE    = 4'h0;
    localparam logic [3:0] FLUSH_ALL   = 4'h1;
    localparam logic [3:0] FLUSH_EARLY = 4'h2;
    localparam logic [3:0] STALL_EARLY = 4'h3;
    localparam logic [3:0] STALL_MMU   = 4'h4;

    localparam logic [2:0] STAGE_IF  = 3'd0;
    localparam logic [2:0] STAGE_ID  = 3'd1;
    localparam logic [2:0] STAGE_EX  = 3'd2;
    localparam logic [2:0] STAGE_MEM = 3'd3;
    localparam logic [2:0] STAGE_WB  = 3'd4;

    typedef enum logic [1:0] {
        HZ_RUN        = 2'd0,
        HZ_MMU_WAIT   = 2'd1,
        HZ_TRAP_DRAIN = 2'd2
    } hz_state_e;

    // Both stall flavours freeze PC and IF/ID; flushes never do.
    function automatic logic is_front_hold(input logic [3:0] haz);
        return (haz == STALL_EARLY) || (haz == STALL_MMU);
    endfunction

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: the ID instruction reads a register that
// the load currently in EX is about to write.
module load_use_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       load_use
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);
    // x0 is never a real dependency.
    assign load_use  = ex_mem_read && (ex_rd != 5'd0) && (rs1_match || rs2_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller: fixed-priority resolution of trap, MMU, branch and
// load-use hazards onto the shared hazard bus, with trap-drain / MMU-wait FSM.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int TRAP_FLUSH_CYCLES = 3,
    parameter int MMU_TIMEOUT       = 256,
    parameter int COUNT_W           = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic               id_uses_rs1,
    input  logic               id_uses_rs2,
    input  logic [4:0]         ex_rd,
    input  logic               ex_mem_read,
    input  logic               ex_branch_taken,
    input  logic               trap_req,
    input  logic               mmu_busy,
    output logic [3:0]         hazard_signal,
    output logic               front_hold,
    output logic               trap_ack,
    output logic [COUNT_W-1:0] stall_count,
    output logic               mmu_timeout
);

    localparam int CNT_W      = $clog2(TRAP_FLUSH_CYCLES + 1);
    localparam int MC_W       = $clog2(MMU_TIMEOUT + 1);
    localparam int DRAIN_INIT = (TRAP_FLUSH_CYCLES > 1) ? TRAP_FLUSH_CYCLES - 2 : 0;
    localparam logic [MC_W-1:0] MC_MAX = MC_W'(MMU_TIMEOUT);

    hz_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MC_W-1:0]    mmu_cnt_q, mmu_cnt_d;
    logic [COUNT_W-1:0] stall_count_q;
    logic               mmu_timeout_q;
    logic [3:0]         haz_d;
    logic               ack_d;
    logic               load_use;

    load_use_detect u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    always_comb begin
        haz_d     = HAZ_NONE;
        ack_d     = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        mmu_cnt_d = mmu_cnt_q;
        case (state_q)
            HZ_RUN, HZ_MMU_WAIT: begin
                if (trap_req) begin
                    haz_d     = FLUSH_ALL;
                    ack_d     = 1'b1;
                    state_d   = (TRAP_FLUSH_CYCLES > 1) ? HZ_TRAP_DRAIN : HZ_RUN;
                    cnt_d     = CNT_W'(DRAIN_INIT);
                    mmu_cnt_d = '0;
                end else if (mmu_busy) begin
                    haz_d   = STALL_MMU;
                    state_d = HZ_MMU_WAIT;
                    if (state_q == HZ_RUN)
                        mmu_cnt_d = MC_W'(1);
                    else if (mmu_cnt_q != MC_MAX)
                        mmu_cnt_d = mmu_cnt_q + MC_W'(1);
                end else begin
                    // Branch wins over load-use: the flushed ID op makes the stall moot.
                    state_d   = HZ_RUN;
                    mmu_cnt_d = '0;
                    if (ex_branch_taken)
                        haz_d = FLUSH_EARLY;
                    else if (load_use)
                        haz_d = STALL_EARLY;
                end
            end
            HZ_TRAP_DRAIN: begin
                haz_d = FLUSH_ALL;
                if (cnt_q == '0)
                    state_d = HZ_RUN;
                else
                    cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = HZ_RUN;
        endcase
    end

    assign hazard_signal = rst ? HAZ_NONE : haz_d;
    assign trap_ack      = rst ? 1'b0 : ack_d;
    assign front_hold    = is_front_hold(hazard_signal);
    assign stall_count   = stall_count_q;
    assign mmu_timeout   = mmu_timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HZ_RUN;
            cnt_q         <= '0;
            mmu_cnt_q     <= '0;
            stall_count_q <= '0;
            mmu_timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mmu_cnt_q <= mmu_cnt_d;
            if (front_hold && (stall_count_q != {COUNT_W{1'b1}}))
                stall_count_q <= stall_count_q + COUNT_W'(1);
            if ((haz_d == STALL_MMU) && (mmu_cnt_d >= MC_MAX))
                mmu_timeout_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (TRAP_FLUSH_CYCLES=3, MMU_TIMEOUT=8).
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic        ex_branch_taken, trap_req, mmu_busy;
    logic [3:0]  hazard_signal;
    logic        front_hold, trap_ack, mmu_timeout;
    logic [31:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .TRAP_FLUSH_CYCLES (3),
        .MMU_TIMEOUT       (8),
        .COUNT_W           (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .trap_req        (trap_req),
        .mmu_busy        (mmu_busy),
        .hazard_signal   (hazard_signal),
        .front_hold      (front_hold),
        .trap_ack        (trap_ack),
        .stall_count     (stall_count),
        .mmu_timeout     (mmu_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs: hazard, front_hold, trap_ack, stall_count, mmu_timeout.
    task automatic check_all(input string tag, input logic [3:0] haz, input logic hold,
                             input logic ack, input logic [31:0] cnt, input logic tmo);
        #1;
        check({tag, ".haz"},  32'(hazard_signal), 32'(haz));
        check({tag, ".hold"}, 32'(front_hold),    32'(hold));
        check({tag, ".ack"},  32'(trap_ack),      32'(ack));
        check({tag, ".cnt"},  stall_count,        cnt);
        check({tag, ".tmo"},  32'(mmu_timeout),   32'(tmo));
        $display("step %-12s haz=%0h hold=%0b ack=%0b cnt=%0d tmo=%0b",
                 tag, hazard_signal, front_hold, trap_ack, stall_count, mmu_timeout);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; trap_req = 1'b0; mmu_busy = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        trap_req = 1'b1; mmu_busy = 1'b1;
        check_all("rst_forced", HAZ_NONE, 1'b0, 1'b0, 32'd0, 1'b0);
        tick(); tick();
        check_all("rst_hold", HAZ_NONE, 1'b0, 1'b0, 32'd0, 1'b0);
        rst = 1'b0;
        clear_inputs();
        check_all("idle", HAZ_NONE, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();

        // Load-use on rs2
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        check_all("lu_rs2", STALL_EARLY, 1'b1, 1'b0, 32'd0, 1'b0);
        tick();
        ex_rd = 5'd0; id_rs2 = 5'd0;
        check_all("lu_x0", HAZ_NONE, 1'b0, 1'b0, 32'd1, 1'b0);
        tick();
        // Load-use on rs1, then same regs with the use flag dropped
        ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b0;
        check_all("lu_rs1", STALL_EARLY, 1'b1, 1'b0, 32'd1, 1'b0);
        tick();
        id_uses_rs1 = 1'b0;
        check_all("lu_nouse", HAZ_NONE, 1'b0, 1'b0, 32'd2, 1'b0);
        tick();
        ex_mem_read = 1'b0; id_uses_rs1 = 1'b1;
        check_all("lu_noload", HAZ_NONE, 1'b0, 1'b0, 32'd2, 1'b0);
        tick();

        // Branch together with a load-use match
        clear_inputs();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        ex_branch_taken = 1'b1;
        check_all("br_lu", FLUSH_EARLY, 1'b0, 1'b0, 32'd2, 1'b0);
        tick();

        // Four MMU stall cycles, then exit with a branch
        clear_inputs();
        mmu_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_all($sformatf("mmu4_%0d", i), STALL_MMU, 1'b1, 1'b0, 32'(2 + i), 1'b0);
            tick();
        end
        mmu_busy = 1'b0; ex_branch_taken = 1'b1;
        check_all("mmu4_exit", FLUSH_EARLY, 1'b0, 1'b0, 32'd6, 1'b0);
        tick();
        ex_branch_taken = 1'b0;
        check_all("mmu4_run", HAZ_NONE, 1'b0, 1'b0, 32'd6, 1'b0);
        tick();

        // Trap during MMU wait: three FLUSH_ALL, one ack, mmu ignored
        mmu_busy = 1'b1;
        check_all("trap_pre", STALL_MMU, 1'b1, 1'b0, 32'd6, 1'b0);
        tick();
        trap_req = 1'b1;
        check_all("trap_c0", FLUSH_ALL, 1'b0, 1'b1, 32'd7, 1'b0);
        tick();
        check_all("trap_c1", FLUSH_ALL, 1'b0, 1'b0, 32'd7, 1'b0);
        tick();
        trap_req = 1'b0; ex_branch_taken = 1'b1;
        check_all("trap_c2", FLUSH_ALL, 1'b0, 1'b0, 32'd7, 1'b0);
        tick();
        ex_branch_taken = 1'b0;
        check_all("trap_after", STALL_MMU, 1'b1, 1'b0, 32'd7, 1'b0);
        tick();
        mmu_busy = 1'b0;
        check_all("trap_idle", HAZ_NONE, 1'b0, 1'b0, 32'd8, 1'b0);
        tick();

        // MMU timeout: flag visible after the 8th consecutive stall cycle
        mmu_busy = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            check_all($sformatf("tmo_%0d", k), STALL_MMU, 1'b1, 1'b0, 32'(8 + k - 1), 1'(k > 8));
            tick();
        end
        mmu_busy = 1'b0;
        check_all("tmo_sticky", HAZ_NONE, 1'b0, 1'b0, 32'd18, 1'b1);
        tick();
        check_all("tmo_sticky2", HAZ_NONE, 1'b0, 1'b0, 32'd18, 1'b1);

        // Reset mid-drain clears everything with no residual flush
        trap_req = 1'b1;
        check_all("rd_trap", FLUSH_ALL, 1'b0, 1'b1, 32'd18, 1'b1);
        tick();
        trap_req = 1'b0;
        rst = 1'b1;
        check_all("rd_in_rst", HAZ_NONE, 1'b0, 1'b0, 32'd18, 1'b1);
        tick();
        rst = 1'b0;
        check_all("rd_after", HAZ_NONE, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        check_all("rd_after2", HAZ_NONE, 1'b0, 1'b0, 32'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
